// File: rtl/counter_ctrl_pkg.sv
// Shared types for the command-driven counter controller: FSM states and opcodes.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SET_TC    = 3'd1;
  localparam logic [2:0] OP_SET_MODE  = 3'd2;
  localparam logic [2:0] OP_SET_PRESC = 3'd3;
  localparam logic [2:0] OP_START     = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;
  localparam logic [2:0] OP_CLEAR     = 3'd6;

endpackage

// File: rtl/counter_core.sv
// Up/down counter with synchronous load and an end-value compare.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             dir,
  input  logic [WIDTH-1:0] end_value,
  output logic [WIDTH-1:0] count,
  output logic             at_end
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_count <= '0;
    else if (load)   r_count <= load_value;
    else if (enable) r_count <= dir ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
  end

  assign count  = r_count;
  assign at_end = (r_count == end_value);

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven counter: FSM, prescaler and config registers around counter_core.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_tc, w_tc_nxt;
  logic               r_dir, w_dir_nxt;
  logic               r_ar, w_ar_nxt;
  logic [PRESC_W-1:0] r_presc, w_presc_nxt;
  logic [PRESC_W-1:0] r_p, w_p_nxt;
  logic               r_tc_pulse, w_tc_pulse_nxt;
  logic               r_err, w_err_nxt;

  logic               w_load, w_en, w_at_end, w_step;
  logic [WIDTH-1:0]   w_load_val, w_start_val, w_end_val;

  assign w_start_val = r_dir ? r_tc : '0;
  assign w_end_val   = r_dir ? '0 : r_tc;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_value(w_load_val),
    .enable    (w_en),
    .dir       (r_dir),
    .end_value (w_end_val),
    .count     (count),
    .at_end    (w_at_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tc_nxt       = r_tc;
    w_dir_nxt      = r_dir;
    w_ar_nxt       = r_ar;
    w_presc_nxt    = r_presc;
    w_p_nxt        = r_p;
    w_load         = 1'b0;
    w_load_val     = w_start_val;
    w_en           = 1'b0;
    w_tc_pulse_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    w_step         = (r_state == ST_RUN);

    // Commands that take effect in RUN (CLEAR, STOP) pre-empt the scheduled step.
    if (cmd_valid) begin
      case (cmd_op)
        OP_CLEAR: begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
          w_load_val  = '0;
          w_p_nxt     = '0;
          w_step      = 1'b0;
        end
        OP_STOP: begin
          if (r_state == ST_RUN) begin
            w_state_nxt = ST_PAUSE;
            w_step      = 1'b0;
          end
        end
        OP_START: begin
          if (r_state == ST_IDLE || r_state == ST_DONE) begin
            w_state_nxt = ST_RUN;
            w_load      = 1'b1;
            w_p_nxt     = '0;
          end else if (r_state == ST_PAUSE) begin
            w_state_nxt = ST_RUN;
          end
        end
        OP_SET_TC: begin
          if (r_state == ST_RUN) w_err_nxt = 1'b1;
          else                   w_tc_nxt  = cmd_data;
        end
        OP_SET_MODE: begin
          if (r_state == ST_RUN) w_err_nxt = 1'b1;
          else begin
            w_dir_nxt = cmd_data[0];
            w_ar_nxt  = cmd_data[1];
          end
        end
        OP_SET_PRESC: begin
          if (r_state == ST_RUN) w_err_nxt   = 1'b1;
          else                   w_presc_nxt = PRESC_W'(cmd_data);
        end
        default: ;
      endcase
    end

    if (w_step) begin
      if (r_p != r_presc) begin
        w_p_nxt = r_p + PRESC_W'(1);
      end else begin
        w_p_nxt = '0;
        if (w_at_end) begin
          w_tc_pulse_nxt = 1'b1;
          if (r_ar) w_load      = 1'b1;
          else      w_state_nxt = ST_DONE;
        end else begin
          w_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tc       <= '1;
      r_dir      <= 1'b0;
      r_ar       <= 1'b0;
      r_presc    <= '0;
      r_p        <= '0;
      r_tc_pulse <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tc       <= w_tc_nxt;
      r_dir      <= w_dir_nxt;
      r_ar       <= w_ar_nxt;
      r_presc    <= w_presc_nxt;
      r_p        <= w_p_nxt;
      r_tc_pulse <= w_tc_pulse_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign cmd_ready = 1'b1;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign tc_pulse  = r_tc_pulse;
  assign err       = r_err;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: directed scenarios plus random commands vs. a behavioural model.
module tb_counter_ctrl;
  localparam int W    = 4;
  localparam int PW   = 4;
  localparam int MASK = (1 << W) - 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] count;
  logic         tc_pulse, busy, done, err;

  counter_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .count    (count),
    .tc_pulse (tc_pulse),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_state, m_count, m_p, m_tc, m_dir, m_ar, m_presc;
  int e_tc, e_err;

  typedef logic [W+3:0] obs_t;   // {count, tc_pulse, busy, done, err}
  obs_t sb_q[$];

  function automatic void model_reset();
    m_state = M_IDLE; m_count = 0; m_p = 0;
    m_tc = MASK; m_dir = 0; m_ar = 0; m_presc = 0;
    e_tc = 0; e_err = 0;
  endfunction

  // One clock edge of the counter as described behaviourally.
  function automatic void model_step(input bit v, input int op, input int d);
    int startv, endv;
    bit tick;
    startv = m_dir ? m_tc : 0;
    endv   = m_dir ? 0 : m_tc;
    tick   = (m_state == M_RUN);
    e_tc   = 0;
    e_err  = 0;
    if (v) begin
      if (op == 6) begin
        m_state = M_IDLE; m_count = 0; m_p = 0; tick = 0;
      end else if (op == 5) begin
        if (m_state == M_RUN) begin m_state = M_PAUSE; tick = 0; end
      end else if (op == 4) begin
        if (m_state == M_IDLE || m_state == M_DONE) begin
          m_state = M_RUN; m_count = startv; m_p = 0; tick = 0;
        end else if (m_state == M_PAUSE) begin
          m_state = M_RUN;
        end
      end else if (op >= 1 && op <= 3) begin
        if (m_state == M_RUN) e_err = 1;
        else if (op == 1) m_tc = d;
        else if (op == 2) begin m_dir = d % 2; m_ar = (d / 2) % 2; end
        else m_presc = d % (1 << PW);
      end
    end
    if (tick) begin
      if (m_p < m_presc) m_p = m_p + 1;
      else begin
        m_p = 0;
        if (m_count == endv) begin
          e_tc = 1;
          if (m_ar) m_count = startv;
          else      m_state = M_DONE;
        end else begin
          m_count = m_dir ? (m_count + MASK) % (MASK + 1) : (m_count + 1) % (MASK + 1);
        end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o[W+3:4] = W'(m_count);
    o[3]     = (e_tc != 0);
    o[2]     = (m_state == M_RUN);
    o[1]     = (m_state == M_DONE);
    o[0]     = (e_err != 0);
    return o;
  endfunction

  task automatic cyc(input bit v, input int op, input int d);
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op[2:0];
    cmd_data  = d[W-1:0];
    model_step(v, op, d);
    sb_q.push_back(model_obs());
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_tc_pulse", int'(tc_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every edge presents an output, compare it with the queued expectation.
  initial begin
    obs_t ex, ac;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        ac = {count, tc_pulse, busy, done, err};
        total++;
        if (ac !== ex) begin
          bad++;
          $display("FAIL scoreboard t=%0t: got cnt=%0d tc=%b busy=%b done=%b err=%b, want cnt=%0d tc=%b busy=%b done=%b err=%b",
                   $time, ac[W+3:4], ac[3], ac[2], ac[1], ac[0],
                   ex[W+3:4], ex[3], ex[2], ex[1], ex[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    model_reset();
    #1;
    chk("init_count", int'(count), 0);
    chk("init_busy", int'(busy), 0);
    chk("ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // Up count to 5, single tc_pulse, then DONE holding 5
    cyc(1, 1, 5); cyc(1, 4, 0); nops(8);
    chk("up_done_count", int'(count), 5);
    chk("up_done_flag", int'(done), 1);

    // Down with auto-reload, prescale 1
    do_reset();
    cyc(1, 2, 3); cyc(1, 1, 3); cyc(1, 3, 1); cyc(1, 4, 0); nops(20);
    chk("reload_busy", int'(busy), 1);

    // Mid-run async reset, then pause/retarget/resume
    do_reset();
    cyc(1, 1, 5); cyc(1, 4, 0); nops(2);
    cyc(1, 5, 0); cyc(1, 1, 9); cyc(1, 4, 0); nops(10);
    chk("resume_count", int'(count), 9);
    chk("resume_done", int'(done), 1);

    // Config write while running is rejected
    do_reset();
    cyc(1, 1, 8); cyc(1, 4, 0); cyc(0, 0, 0); cyc(1, 1, 2); nops(10);
    chk("rejected_tc_count", int'(count), 8);

    // STOP on the terminal step, then CLEAR
    do_reset();
    cyc(1, 1, 2); cyc(1, 4, 0); nops(2); cyc(1, 5, 0); nops(2);
    chk("stop_term_count", int'(count), 2);
    chk("stop_term_done", int'(done), 0);
    cyc(1, 6, 0); nops(1);
    chk("clear_count", int'(count), 0);

    // tc equals start value: terminal on every step under reload
    do_reset();
    cyc(1, 1, 0); cyc(1, 2, 2); cyc(1, 3, 2); cyc(1, 4, 0); nops(12);

    // Down without reload reaching 0, then restart from DONE
    do_reset();
    cyc(1, 2, 1); cyc(1, 1, 4); cyc(1, 4, 0); nops(7); cyc(1, 4, 0); nops(3);

    // Random command traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else if ($urandom_range(0, 3) == 0)
        cyc(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)));
      else
        cyc(1'b0, 0, 0);
    end

    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
